toggle_stim_gen: RTL and testbench
==================================

// Module: toggle_stim_gen
// PURPOSE
//   Synthesisable multi-channel square-wave stimulus generator. Replaces
//   hard-coded "always #N x = ~x" bench toggles with per-channel
//   programmable half-periods, initial levels and a bounded run length.
//   Drives DUT inputs in benches and on-chip self-test; IDLE/RUN/DONE control.
// PARAMETERS
//   NUM_CH  4   number of stimulus channels
//   CNT_W   12  width of each per-channel half-period field/counter
//   RUN_W   16  width of run-length field/counter (RUN cycles before DONE)
// PORTS
//   clk          in   1            rising-edge clock
//   reset        in   1            asynchronous, active-high reset
//   start        in   1            level-sampled; accepted only in IDLE
//   abort        in   1            stop RUN, return to IDLE without done
//   half_period  in   NUM_CH*CNT_W ch k at [k*CNT_W +: CNT_W]; 0 = channel held
//   init_val     in   NUM_CH       per-channel level loaded at start
//   run_cycles   in   RUN_W        number of RUN cycles; 0 = immediate DONE
//   stim_out     out  NUM_CH       generated waveforms, registered
//   busy         out  1            high while in RUN
//   done         out  1            one-cycle pulse on completion
// BEHAVIOUR
//   - reset (async, any time incl. mid-RUN): state=IDLE, stim_out=0, busy=0,
//     done=0, all counters=0. Takes effect without a clock edge.
//   - IDLE: start=1 at edge E0 -> latch half_period/init_val/run_cycles,
//     stim_out<=init_val, ch counters<=0, run_cnt<=0; if run_cycles==0 go
//     DONE, else go RUN with busy=1. Config inputs ignored after latch.
//   - RUN, each edge: run_cnt++; per channel with hp!=0: if cnt==hp-1 then
//     cnt<=0, stim_out[k] toggles, else cnt++. First toggle hp edges after
//     E0; full period 2*hp cycles. hp==0: stim_out[k] held at init_val[k].
//   - RUN exit: on edge where run_cnt==run_cycles-1 go DONE; toggles due on
//     that edge still apply. Exactly run_cycles RUN edges occur.
//   - abort=1 in RUN: next edge -> IDLE, busy=0, stim_out=0, done stays 0.
//     abort beats run expiry on the same edge. abort outside RUN ignored.
//   - start during RUN or DONE ignored (no re-trigger, no queueing).
//   - DONE: done=1, busy=0, stim_out frozen at last value for one cycle;
//     next edge -> IDLE (stim_out retains value until next start).
//   - Counters never wrap: cnt bounded by hp-1, run_cnt by run_cycles-1.
// CONFIGURATION
//   TOGGLE_CNT_EN defined: adds output toggle_cnt [NUM_CH*RUN_W-1:0],
//     ch k at [k*RUN_W +: RUN_W]; cleared at start accept and reset,
//     +1 per toggle of ch k, held through DONE/IDLE; cleared (not held) on abort.
//   TOGGLE_CNT_EN undefined: port and counters absent; all else identical.
// TESTING
//   1. hp={ch3..ch0}={0,3,2,1}, init=4'b1010, run=12, start 1 cycle ->
//      ch0 toggles every edge, ch1 every 2, ch2 every 3, ch3 stays 1; busy
//      high 12 cycles; done pulses once; final stim_out=4'b1010.
//   2. run_cycles=0, init=4'b0110 -> no RUN; stim_out=4'b0110, busy never
//      high, done pulses the cycle after start.
//   3. test 1 config, abort asserted at RUN edge 5 -> IDLE next edge,
//      stim_out=0, busy=0, done never asserts.
//   4. test 1 config, reset pulsed mid-cycle at RUN edge 7 -> stim_out=0,
//      busy=0 immediately (before next clk edge); restart runs cleanly.
//   5. start held high through RUN and DONE, config changed mid-RUN ->
//      single run, waveforms match test 1, no re-trigger after DONE.
//   6. TOGGLE_CNT_EN, test 1 config -> toggle_cnt ch0..ch3 = 12,6,4,0 at done.

Source files
------------

// File: rtl/toggle_stim_gen.sv
// Multi-channel square-wave stimulus generator with IDLE/RUN/DONE control.
// Define TOGGLE_CNT_EN to add the per-channel toggle_cnt output.
module toggle_stim_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12,
  parameter int RUN_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CH*CNT_W-1:0] half_period,
  input  logic [NUM_CH-1:0]       init_val,
  input  logic [RUN_W-1:0]        run_cycles,
  output logic [NUM_CH-1:0]       stim_out,
  output logic                    busy,
`ifdef TOGGLE_CNT_EN
  output logic [NUM_CH*RUN_W-1:0] toggle_cnt,
`endif
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_e                         state_q, state_d;
  logic [NUM_CH-1:0]              stim_q, stim_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   hp_q, hp_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [RUN_W-1:0]               run_len_q, run_len_d;
  logic [RUN_W-1:0]               run_cnt_q, run_cnt_d;
`ifdef TOGGLE_CNT_EN
  logic [NUM_CH-1:0][RUN_W-1:0]   tcnt_q, tcnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    hp_d      = hp_q;
    ch_cnt_d  = ch_cnt_q;
    run_len_d = run_len_q;
    run_cnt_d = run_cnt_q;
`ifdef TOGGLE_CNT_EN
    tcnt_d    = tcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          hp_d      = half_period;
          run_len_d = run_cycles;
          stim_d    = init_val;
          ch_cnt_d  = '0;
          run_cnt_d = '0;
`ifdef TOGGLE_CNT_EN
          tcnt_d    = '0;
`endif
          state_d   = (run_cycles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          stim_d    = '0;
          ch_cnt_d  = '0;
          run_cnt_d = '0;
`ifdef TOGGLE_CNT_EN
          tcnt_d    = '0;
`endif
        end else begin
          // A zero half-period leaves the channel frozen at its initial level.
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (hp_q[k] != '0) begin
              if (ch_cnt_q[k] == hp_q[k] - CNT_ONE) begin
                ch_cnt_d[k] = '0;
                stim_d[k]   = ~stim_q[k];
`ifdef TOGGLE_CNT_EN
                tcnt_d[k]   = tcnt_q[k] + RUN_ONE;
`endif
              end else begin
                ch_cnt_d[k] = ch_cnt_q[k] + CNT_ONE;
              end
            end
          end
          if (run_cnt_q == run_len_q - RUN_ONE) begin
            state_d   = DONE;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + RUN_ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      stim_q    <= '0;
      hp_q      <= '0;
      ch_cnt_q  <= '0;
      run_len_q <= '0;
      run_cnt_q <= '0;
`ifdef TOGGLE_CNT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      hp_q      <= hp_d;
      ch_cnt_q  <= ch_cnt_d;
      run_len_q <= run_len_d;
      run_cnt_q <= run_cnt_d;
`ifdef TOGGLE_CNT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  assign stim_out = stim_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
`ifdef TOGGLE_CNT_EN
  assign toggle_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_toggle_stim_gen.sv
// Directed self-checking bench for toggle_stim_gen (default parameters).
module tb_toggle_stim_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [47:0] half_period;
  logic [3:0]  init_val;
  logic [15:0] run_cycles;
  logic [3:0]  stim_out;
  logic        busy;
  logic        done;
`ifdef TOGGLE_CNT_EN
  logic [63:0] toggle_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // ch3..ch0 half-periods = 0,3,2,1
  localparam logic [47:0] HP1 = {12'd0, 12'd3, 12'd2, 12'd1};

  // Expected stim_out after RUN edge n (n=0 is the start-accept edge), init 4'b1010.
  logic [3:0] exp_tbl [13] = '{4'b1010, 4'b1011, 4'b1000, 4'b1101, 4'b1110,
                               4'b1111, 4'b1000, 4'b1001, 4'b1010, 4'b1111,
                               4'b1100, 4'b1101, 4'b1010};

  toggle_stim_gen #(.NUM_CH(4), .CNT_W(12), .RUN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .half_period(half_period),
    .init_val   (init_val),
    .run_cycles (run_cycles),
    .stim_out   (stim_out),
    .busy       (busy),
`ifdef TOGGLE_CNT_EN
    .toggle_cnt (toggle_cnt),
`endif
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    half_period = '0; init_val = '0; run_cycles = '0;
    #1;
    checks++;
    if ({stim_out, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got stim=%b busy=%b done=%b, want 0000 0 0", stim_out, busy, done);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({stim_out, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got stim=%b busy=%b done=%b, want 0000 0 0", stim_out, busy, done);
    end
  endtask

  // Runs the reference config; hold_start keeps start high and scrambles config mid-run.
  task automatic run_cfg1(input bit hold_start, input string tag);
    half_period = HP1; init_val = 4'b1010; run_cycles = 16'd12;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) tick();
      if (hold_start && n == 3) begin
        half_period = {12'd5, 12'd1, 12'd1, 12'd7};
        init_val = 4'b0101; run_cycles = 16'd3;
      end
      checks++;
      if (stim_out !== exp_tbl[n] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s_run_edge%0d: got stim=%b busy=%b done=%b, want %b 1 0",
                 tag, n, stim_out, busy, done, exp_tbl[n]);
      end
    end
    tick();
    checks++;
    if (stim_out !== 4'b1010 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got stim=%b busy=%b done=%b, want 1010 0 1", tag, stim_out, busy, done);
    end
`ifdef TOGGLE_CNT_EN
    checks++;
    if (toggle_cnt !== {16'd0, 16'd4, 16'd6, 16'd12}) begin
      errors++;
      $display("FAIL %s_toggle_cnt: got %h, want %h", tag, toggle_cnt, {16'd0, 16'd4, 16'd6, 16'd12});
    end
`endif
    tick();
    checks++;
    if (stim_out !== 4'b1010 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: got stim=%b busy=%b done=%b, want 1010 0 0", tag, stim_out, busy, done);
    end
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stim_out !== 4'b1010) begin
      errors++;
      $display("FAIL %s_no_retrigger: got stim=%b busy=%b done=%b, want 1010 0 0", tag, stim_out, busy, done);
    end
  endtask

  task automatic test_basic_run();
    run_cfg1(1'b0, "basic");
  endtask

  task automatic test_zero_run();
    half_period = HP1; init_val = 4'b0110; run_cycles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (stim_out !== 4'b0110 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_run_done: got stim=%b busy=%b done=%b, want 0110 0 1", stim_out, busy, done);
    end
    tick();
    checks++;
    if (stim_out !== 4'b0110 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_run_idle: got stim=%b busy=%b done=%b, want 0110 0 0", stim_out, busy, done);
    end
  endtask

  task automatic test_abort();
    bit seen;
    half_period = HP1; init_val = 4'b1010; run_cycles = 16'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 5; n++) tick();
    checks++;
    if (stim_out !== exp_tbl[4] || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got stim=%b busy=%b, want %b 1", stim_out, busy, exp_tbl[4]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (stim_out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got stim=%b busy=%b done=%b, want 0000 0 0", stim_out, busy, done);
    end
`ifdef TOGGLE_CNT_EN
    checks++;
    if (toggle_cnt !== 64'd0) begin
      errors++;
      $display("FAIL abort_toggle_cnt: got %h, want 0", toggle_cnt);
    end
`endif
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got activity=%b, want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    half_period = HP1; init_val = 4'b1010; run_cycles = 16'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 8; n++) tick();
    checks++;
    if (stim_out !== exp_tbl[7] || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got stim=%b busy=%b, want %b 1", stim_out, busy, exp_tbl[7]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (stim_out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: got stim=%b busy=%b done=%b, want 0000 0 0", stim_out, busy, done);
    end
    #2 reset = 1'b0;
    run_cfg1(1'b0, "restart");
  endtask

  task automatic test_start_held();
    run_cfg1(1'b1, "held");
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_zero_run();
    test_abort();
    test_async_reset();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
